// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: STAGES slots of {valid, ctrl, data}
// with stall, bubble and flush, plus a saturating bubble counter. Updates on the falling edge.
module pipe_stage_reg #(
    parameter int DATA_W     = 128,
    parameter int CTRL_W     = 9,
    parameter int STAGES     = 1,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              busy
);

    logic [STAGES-1:0] valid_q;
    logic [CTRL_W-1:0] ctrl_q [STAGES];
    logic [DATA_W-1:0] data_q [STAGES];
    logic [CNT_W-1:0]  cnt_q;
    logic              count_evt;

    // Priority is rst > flush > stall > bubble > advance; killed slots always get ctrl=0
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                ctrl_q[s] <= '0;
                data_q[s] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                ctrl_q[s] <= '0;
                if (CLEAR_DATA != 0) begin
                    data_q[s] <= '0;
                end
            end
        end else if (!stall) begin
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s] <= valid_q[s-1];
                ctrl_q[s]  <= ctrl_q[s-1];
                data_q[s]  <= data_q[s-1];
            end
            if (bubble) begin
                valid_q[0] <= 1'b0;
                ctrl_q[0]  <= '0;
                if (CLEAR_DATA != 0) begin
                    data_q[0] <= '0;
                end
            end else begin
                valid_q[0] <= in_valid;
                ctrl_q[0]  <= in_valid ? in_ctrl : '0;
                data_q[0]  <= (in_valid || CLEAR_DATA == 0) ? in_data : '0;
            end
        end
    end

    // A flush that coincides with a bubble is one inserted bubble, not two
    assign count_evt = flush || (bubble && !stall);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (count_evt && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid  = valid_q[STAGES-1];
    assign out_ctrl   = ctrl_q[STAGES-1];
    assign out_data   = data_q[STAGES-1];
    assign bubble_cnt = cnt_q;
    assign busy       = |valid_q;

    // An invalid slot must never carry live control bits downstream
    for (genvar s = 0; s < STAGES; s++) begin : g_inv
        a_ctrl_zero : assert property (@(negedge clk) disable iff (rst)
            (valid_q[s] || (ctrl_q[s] == '0)));
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register: the generalised successor to the fixed-field inter-stage registers between decode/execute, memory and writeback. It carries an opaque payload plus a control vector through STAGES register slots. It supports per-cycle stall (hold), bubble insertion (load-use hazard), and full flush (branch redirect), and tracks slot validity. It also keeps a saturating count of inserted bubbles for hazard-rate profiling. It drops in anywhere between two pipeline stages.

## Interface
- DATA_W, 128, payload width (PC+4, operands, immediate, register numbers, funct…)
- CTRL_W, 9, control-vector width (WB/M/EX bits); forced to zero in every invalid slot
- STAGES, 1, number of series register slots (1..4); >1 used for retiming
- CLEAR_DATA, 1, 1: payload zeroed on bubble/flush/invalid; 0: payload of killed slot held (power saving)
- CNT_W, 16, bubble-counter width

- clk  in  1  clock; all state updates on the falling edge, matching the rest of the pipeline
- rst  in  1  asynchronous, active-high reset
- stall  in  1  freeze every slot
- bubble  in  1  slot 0 loads a bubble; slots 1..STAGES-1 advance normally
- flush  in  1  every slot loads a bubble
- in_valid  in  1  upstream slot holds a real instruction
- in_ctrl  in  CTRL_W  upstream control vector
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  last slot valid
- out_ctrl  out  CTRL_W  last slot control (zero when out_valid=0)
- out_data  out  DATA_W  last slot payload
- bubble_cnt  out  CNT_W  saturating count of bubbles inserted into slot 0
- busy  out  1  OR of all slot valid bits

## Operation
- State: per slot s, valid[s], ctrl[s], data[s]. Outputs come from slot STAGES-1 directly, with no combinational path from inputs.
- Per falling edge, priority rst > flush > stall > bubble > advance:
  - flush: all valid=0, all ctrl=0; data=0 if CLEAR_DATA else held. bubble_cnt += 1.
  - stall (no flush): all slots hold; bubble_cnt unchanged. bubble is ignored while stalled.
  - bubble (no flush/stall): slot 0 killed as under flush; slot s≥1 loads slot s-1. bubble_cnt += 1.
  - advance: slot 0 loads {in_valid, in_valid ? in_ctrl : 0, in_data}. When in_valid=0 and CLEAR_DATA=1, data=0. Slot s≥1 loads slot s-1.
- Invariant, checked by assertion: valid[s]=0 ⇒ ctrl[s]=0, for every slot and every cycle.
- bubble_cnt saturates at 2^CNT_W−1 and never wraps. in_valid=0 on advance is not counted as a bubble.
- busy=0 ⇒ the pipeline segment is drained. Used by the exception/halt logic.

## Timing
- Reset, asynchronous and immediate on rst rise: valid=0, ctrl=0, data=0 in all slots; out_valid=0, out_ctrl=0, out_data=0, bubble_cnt=0, busy=0. Reset overrides CLEAR_DATA.
- Reset mid-operation discards all in-flight slots. The first load occurs on the first falling edge after rst deasserts.
- Latency: in_* to out_* = STAGES falling edges with no stall. Each stall cycle adds exactly one edge.
- Throughput: one item per edge when stall=bubble=flush=0.
- Simultaneous flush+stall: flush wins and all slots are cleared. Simultaneous stall+bubble: stall wins and slot 0 is not killed. Simultaneous flush+bubble: counted once.
- STAGES=1: bubble and flush are equivalent except for priority relative to stall.

## Test plan
- Reset/flow, STAGES=2: assert rst mid-stream, release, then feed data 0x10,0x11,0x12 with ctrl 0x1FF. Required: all outputs 0 during rst; out_data=0x10 on the 2nd edge after first load, then one item per edge.
- Stall: with STAGES=1 and 0xAA loaded, hold stall for 3 edges while in_data=0xBB. Required: out_data stays 0xAA for 3 edges; 0xBB appears on the 4th.
- Bubble, STAGES=2: slots hold A,B; pulse bubble with input C. Required: next edge out=A valid, then out=bubble (valid=0, ctrl=0, data=0). C is lost, since upstream holds it. bubble_cnt=1.
- Flush priority: flush+stall in the same edge with slots full. Required: out_valid=0, ctrl=0, busy=0. With CLEAR_DATA=0, out_data keeps its prior value.
- Invalid input: advance with in_valid=0, in_ctrl=0x1FF. Required: out_ctrl=0, out_valid=0, bubble_cnt unchanged.
- Saturation, CNT_W=4: apply 20 bubble pulses. Required: bubble_cnt stops at 15; a subsequent flush leaves it at 15.
